// File: rtl/jt51_modbuf.sv
// Modulation-input generator: keeps per-channel operator history and registers
// the phase-modulation input (and carrier flag) for the slot after the current one.
module jt51_modbuf #(
    parameter int  CH    = 8,
    parameter int  W     = 14,
    parameter int  LAT   = 2,
    localparam int SLOTS = 4*CH,
    localparam int SW    = $clog2(SLOTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    input  logic                zero,
    input  logic [2:0]          alg,
    input  logic [2:0]          fb,
    input  logic signed [W-1:0] op_in,
    output logic [SW-1:0]       slot,
    output logic signed [W:0]   mod_out,
    output logic                is_carrier
);
    localparam int CW = $clog2(CH);
    localparam logic [1:0] G_M1 = 2'd0;
    localparam logic [1:0] G_C1 = 2'd1;
    localparam logic [1:0] G_M2 = 2'd2;
    localparam logic [1:0] G_C2 = 2'd3;

    logic [SW-1:0]       cnt_q;
    logic signed [W-1:0] p1 [CH];
    logic signed [W-1:0] pp [CH];
    logic signed [W-1:0] c1 [CH];
    logic signed [W-1:0] m2 [CH];

    int                  cur_i, d_i, w_i;
    logic [1:0]          gd, gw;
    logic [CW-1:0]       nd, nw;
    logic                fwd;
    logic signed [W-1:0] p1_s, pp_s, c1_s, m2_s;
    logic signed [W:0]   m1_x, pp_x, c1_x, m2_x, fb_sum, mod_next;
    logic                car_next;

    always_comb begin
        cur_i = zero ? 0 : int'(cnt_q);
        d_i   = (cur_i + 1) % SLOTS;
        w_i   = (cur_i + SLOTS - LAT) % SLOTS;
        gd    = 2'(d_i / CH);
        nd    = CW'(d_i % CH);
        gw    = 2'(w_i / CH);
        nw    = CW'(w_i % CH);
        slot  = rst ? '0 : SW'(cur_i);
    end

    // A value being written this cen overrides the stored copy it replaces.
    always_comb begin
        fwd  = (nw == nd);
        p1_s = (fwd && gw == G_M1) ? op_in  : p1[nd];
        pp_s = (fwd && gw == G_M1) ? p1[nd] : pp[nd];
        c1_s = (fwd && gw == G_C1) ? op_in  : c1[nd];
        m2_s = (fwd && gw == G_M2) ? op_in  : m2[nd];
        m1_x = {p1_s[W-1], p1_s};
        pp_x = {pp_s[W-1], pp_s};
        c1_x = {c1_s[W-1], c1_s};
        m2_x = {m2_s[W-1], m2_s};
        fb_sum = m1_x + pp_x;
    end

    always_comb begin
        mod_next = '0;
        car_next = 1'b0;
        case (gd)
            G_M1: begin
                if (fb != 3'd0)
                    mod_next = fb_sum >>> (4'd8 - {1'b0, fb});
                car_next = (alg == 3'd7);
            end
            G_C1: begin
                case (alg)
                    3'd0, 3'd3, 3'd4, 3'd5, 3'd6: mod_next = m1_x;
                    default:                      mod_next = '0;
                endcase
                car_next = alg[2];
            end
            G_M2: begin
                case (alg)
                    3'd0, 3'd2: mod_next = c1_x;
                    3'd1:       mod_next = m1_x + c1_x;
                    3'd5:       mod_next = m1_x;
                    default:    mod_next = '0;
                endcase
                car_next = alg[2];
            end
            default: begin
                case (alg)
                    3'd0, 3'd1, 3'd4: mod_next = m2_x;
                    3'd2:             mod_next = m1_x + m2_x;
                    3'd3:             mod_next = c1_x + m2_x;
                    3'd5:             mod_next = m1_x;
                    default:          mod_next = '0;
                endcase
                car_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            mod_out    <= '0;
            is_carrier <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                p1[i] <= '0;
                pp[i] <= '0;
                c1[i] <= '0;
                m2[i] <= '0;
            end
        end else if (cen) begin
            cnt_q      <= SW'(d_i);
            mod_out    <= mod_next;
            is_carrier <= car_next;
            case (gw)
                G_M1: begin
                    pp[nw] <= p1[nw];
                    p1[nw] <= op_in;
                end
                G_C1:    c1[nw] <= op_in;
                G_M2:    m2[nw] <= op_in;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jt51_modbuf.sv
// Directed bench for jt51_modbuf (CH=8, W=14, LAT=7): stimulus pushes expected
// responses into a queue, a monitor pops and compares after each cen edge.
module tb_jt51_modbuf;
    localparam int CH  = 8;
    localparam int W   = 14;
    localparam int LAT = 7;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cen = 1'b0;
    logic                zero = 1'b0;
    logic [2:0]          alg = 3'd0;
    logic [2:0]          fb = 3'd0;
    logic signed [W-1:0] op_in = '0;
    logic [4:0]          slot;
    logic signed [W:0]   mod_out;
    logic                is_carrier;

    jt51_modbuf #(.CH(CH), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cen(cen), .zero(zero), .alg(alg), .fb(fb),
        .op_in(op_in), .slot(slot), .mod_out(mod_out), .is_carrier(is_carrier)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk;
        int m;
        bit c;
        int d;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tb_cur = 0;
    int   opv [32];
    int   algc [8];
    int   fbc [8];
    bit   chk [32];
    int   expm [32];
    bit   expc [32];

    always @(posedge clk) begin
        if (cen && !rst) begin
            exp_t e;
            #1;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty: output with no expected entry, mod_out=%0d", mod_out);
            end else begin
                e = q.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if (int'(mod_out) != e.m || is_carrier != e.c) begin
                        n_err++;
                        $display("FAIL mod_slot%0d: got mod_out=%0d is_carrier=%0b, want mod_out=%0d is_carrier=%0b",
                                 e.d, mod_out, is_carrier, e.m, e.c);
                    end
                end
            end
        end
    end

    task automatic check_slot(input int c);
        n_vec++;
        if (slot !== 5'(c)) begin
            n_err++;
            $display("FAIL slot: got %0d, want %0d", slot, c);
        end
    endtask

    task automatic cen_step(input bit z);
        int c, d;
        @(negedge clk);
        c = z ? 0 : tb_cur;
        d = (c + 1) % 32;
        cen   = 1'b1;
        zero  = z;
        op_in = 14'(opv[(c + 32 - LAT) % 32]);
        alg   = 3'(algc[d % 8]);
        fb    = 3'(fbc[d % 8]);
        q.push_back('{chk[d], expm[d], expc[d], d});
        #2;
        check_slot(c);
        tb_cur = d;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cen_step(1'b0);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 32; i++) begin
            chk[i] = 1'b0; expm[i] = 0; expc[i] = 1'b0;
        end
    endtask

    task automatic set_exp(input int d, input int m, input bit c);
        chk[d] = 1'b1; expm[d] = m; expc[d] = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_exp();
        for (int i = 0; i < 32; i++) opv[i] = (i + 1) * 37 - 500;
        for (int i = 0; i < 8; i++) begin algc[i] = 0; fbc[i] = 7; end

        // Power-up reset, then traffic that fills the history with non-zero values.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(40);

        // Mid-frame reset with random traffic on the inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst   = 1'b1;
            cen   = 1'($urandom_range(0, 1));
            zero  = 1'($urandom_range(0, 1));
            op_in = 14'($urandom);
            #2;
            check_slot(0);
        end
        @(negedge clk);
        rst = 1'b0; cen = 1'b0; zero = 1'b0;
        tb_cur = 0;

        // Frame A: history just cleared, all M1 outputs must be 0.
        for (int i = 0; i < 32; i++) opv[i] = 0;
        algc[5] = 7;
        fbc[0] = 7; fbc[1] = 7; fbc[2] = 7; fbc[3] = 7;
        fbc[4] = 1; fbc[5] = 0; fbc[6] = 7; fbc[7] = 1;
        opv[3] = 100; opv[4] = 100; opv[5] = 100; opv[6] = -100; opv[7] = -100;
        for (int d = 1; d < 8; d++) set_exp(d, 0, d == 5);
        run(32);

        // Frame B: second M1 sample per channel.
        clear_exp();
        opv[3] = 300; opv[4] = 300; opv[5] = 300; opv[6] = -300; opv[7] = -300;
        run(32);

        // Frame C: feedback from p1+pp.
        set_exp(3, 200, 1'b0);
        set_exp(4, 3, 1'b0);
        set_exp(5, 0, 1'b1);
        set_exp(6, -200, 1'b0);
        set_exp(7, -4, 1'b0);
        run(32);

        // Frame D: operator connections, wide sums and forwarding.
        clear_exp();
        for (int i = 0; i < 32; i++) opv[i] = 0;
        algc[0] = 1; algc[1] = 2; algc[2] = 2; algc[3] = 0;
        algc[4] = 3; algc[5] = 7; algc[6] = 5; algc[7] = 4;
        opv[0] = 1000;  opv[8] = -3000; opv[16] = 555;
        opv[1] = 8191;  opv[9] = -5;    opv[17] = 8191;
        opv[2] = -8192; opv[18] = -8192;
        opv[3] = -1234; opv[11] = 77;   opv[19] = -9;
        opv[4] = 10;    opv[12] = 20;   opv[20] = 30;
        opv[5] = 400;   opv[13] = 500;  opv[21] = 600;
        opv[6] = -700;
        opv[7] = 123;   opv[23] = -456;
        set_exp(8, 0, 1'b0);      set_exp(16, -2000, 1'b0); set_exp(24, 555, 1'b1);
        set_exp(17, -5, 1'b0);    set_exp(25, 16382, 1'b1);
        set_exp(26, -16384, 1'b1);
        set_exp(11, -1234, 1'b0); set_exp(19, 77, 1'b0);    set_exp(27, -9, 1'b1);
        set_exp(12, 10, 1'b0);    set_exp(20, 0, 1'b0);     set_exp(28, 50, 1'b1);
        set_exp(13, 0, 1'b1);     set_exp(21, 0, 1'b1);     set_exp(29, 0, 1'b1);
        set_exp(14, -700, 1'b1);  set_exp(22, -700, 1'b1);  set_exp(30, -700, 1'b1);
        set_exp(15, 123, 1'b1);   set_exp(23, 0, 1'b1);     set_exp(31, -456, 1'b1);
        run(32);

        // Resync at 17, then a full frame ending with slot 0 computed at slot 31.
        clear_exp();
        algc[2] = 6;
        set_exp(10, -8192, 1'b1);
        set_exp(18, 0, 1'b1);
        set_exp(26, 0, 1'b1);
        set_exp(0, 1000, 1'b0);
        run(17);
        cen_step(1'b1);
        run(31);
        cen_step(1'b0);

        @(negedge clk);
        cen = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jt51_modbuf.md
# jt51_modbuf

Parametrised, sequential modulation-input generator for the FM operator pipeline. It holds per-channel operator output history and walks the slot sequence with an internal counter. Each clock-enabled cycle it registers the phase-modulation input for the next slot: the self-feedback term for M1, or the connected operator outputs for M2/C1/C2, according to that channel's algorithm. It sits between the operator output stage and the phase-modulation adder, and replaces the stateless source-select logic.

## Interface
- CH, 8: channels; slots per frame = 4*CH; SW = $clog2(4*CH)
- W, 14: signed operator output width
- LAT, 2: slots between a slot being current and its op_in arriving; legal 1..CH-1
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  clock enable; all state advances only when high
- zero  in  1  with cen, current slot is 0 (frame resync)
- alg  in  3  algorithm of the channel of slot cur+1
- fb  in  3  M1 feedback level of the channel of slot cur+1
- op_in  in  W signed  operator output of slot (cur-LAT) mod 4*CH
- slot  out  SW  current slot index cur
- mod_out  out  W+1 signed  modulation input for slot cur+1, registered
- is_carrier  out  1  slot cur+1 is a carrier under alg, registered

## Operation
- Slot index: group g = s / CH (0 M1, 1 C1, 2 M2, 3 C2), channel n = s mod CH.
- cur = zero ? 0 : cnt_q. On cen: cnt_q <= (cur+1) mod 4*CH; slot output = cur (combinational).
- Write on cen: slot w = (cur-LAT) mod 4*CH. If w is M1: pp[n] <= p1[n], p1[n] <= op_in. If w is C1 or M2: store in c1[n] or m2[n]. C2: no storage.
- Compute on cen for d = cur+1, channel n:
  - M1: fb=0 -> 0; else (p1[n]+pp[n]) >>> (8-fb), sum at W+1 bits.
  - Connections by alg:
    - 0: C1<-M1, M2<-C1, C2<-M2
    - 1: M2<-M1+C1, C2<-M2
    - 2: M2<-C1, C2<-M1+M2
    - 3: C1<-M1, C2<-C1+M2
    - 4: C1<-M1, C2<-M2
    - 5: C1, M2, C2 each <-M1
    - 6: C1<-M1
    - 7: none
    - Any source not listed gives 0. The M1 source is p1[n].
  - Single source: sign-extend to W+1. Two sources: W+1-bit sum, no overflow possible.
  - is_carrier: C2 always. Also C1 for alg>=4, M2 for alg>=4, M1 for alg 7.
- Forwarding: if the write slot of this cen is a source of d's channel, use op_in instead of stored value; for M1 feedback, forward as p1=op_in, pp=old p1.
- Registers without cen hold.

## Timing
- Reset (sync, rst high at clk edge): cnt_q=0, mod_out=0, is_carrier=0, all p1/pp/c1/m2=0. slot reads 0 while rst held (cnt_q=0, zero ignored for state).
- Reset mid-frame discards history; first cen after release treats cur as 0 unless zero.
- Latency: alg/fb/history sampled at cen of cur -> mod_out valid from next clk edge, stable until next cen.
- Wrap: cur=4*CH-1 computes d=0 (M1 ch0); write index wraps modulo 4*CH.
- zero with cen mid-frame: counter jumps, no state cleared.
- Source-to-destination distance >= CH slots, so LAT<=CH-1 guarantees a value is written no later than the cen that reads it (LAT=CH-1 needs forwarding).

## Test plan
- Reset: rst during random traffic, then 1 cen -> mod_out=0, is_carrier=0, slot=0 then 1; all feedback outputs 0 for first frame.
- Feedback: CH=8, fb=7, M1 ch3 outputs 100 then 300 -> next M1 ch3 mod_out = 400>>>1 = 200; fb=1 -> 400>>>7 = 3; fb=0 -> 0; negative -400, fb=7 -> -200.
- alg 1: ch0 M1=1000, C1=-3000 -> M2 ch0 mod_out=-2000; C2 ch0 mod_out = M2 output; is_carrier=1 only for C2.
- Saturation-free sum: W=14, M1=8191, M2=8191 under alg 2 -> C2 mod_out=16382 at 15 bits; -8192 + -8192 -> -16384.
- Forwarding: LAT=CH-1=7, alg 0, M1 ch0 op_in arrives the same cen C1 ch0 is computed -> mod_out equals that op_in, not the stale value.
- Resync/wrap: zero asserted at cnt_q=17 -> slot=0 that cycle, 1 next; run 32 cens -> slot sequence 0..31,0 with mod_out for slot 0 computed at slot 31.
